step_clock_ctrl: RTL
====================

STEP_CLOCK_CTRL -- requirements
Module: step_clock_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning stable-input cycles required to accept a push edge (10 ms at 50 MHz).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning flip-flop depth of every input synchronizer.
REQ-003 SHALL have port clk, input, 1, the single system clock (50 MHz FPGA clock).
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port push, input, 1, raw asynchronous step push-button.
REQ-006 SHALL have port ena_switch, input, 1, raw mode switch: 0 = free-run, 1 = single-step.
REQ-007 SHALL have port switches_in, input, 3, raw configuration switches.
REQ-008 SHALL have port cpu_en, output, 1, clock enable to the processor core.
REQ-009 SHALL have port sw_sync, output, 3, synchronized switches_in.
REQ-010 SHALL have port step_pulse, output, 1, one-cycle strobe per accepted press.
REQ-011 SHALL have port step_count, output, 8, number of accepted presses, for LED display.

Function
REQ-012 SHALL pass push, ena_switch and switches_in through SYNC_STAGES flip-flops before any use; sw_sync lags switches_in by SYNC_STAGES edges.
REQ-013 SHALL implement a debounce FSM with states IDLE, DB_PRESS, HELD, DB_RELEASE and a counter wide enough for DEBOUNCE_CYCLES-1.
REQ-014 IDLE: synchronized push=1 -> DB_PRESS, counter cleared to 0.
REQ-015 DB_PRESS: push=0 -> IDLE; push=1 and counter=DEBOUNCE_CYCLES-1 -> HELD; otherwise counter increments.
REQ-016 On the DB_PRESS->HELD transition, step_pulse SHALL be registered high for exactly one cycle.
REQ-017 With push held high, step_pulse SHALL be high in the cycle following the (SYNC_STAGES+DEBOUNCE_CYCLES)th rising edge after the first edge that samples push=1.
REQ-018 HELD: push=0 -> DB_RELEASE, counter cleared; holding push indefinitely SHALL produce no further pulses.
REQ-019 DB_RELEASE: push=1 -> HELD, with no pulse; push=0 and counter=DEBOUNCE_CYCLES-1 -> IDLE; otherwise counter increments.
REQ-020 step_count SHALL increment by 1 on every step_pulse in either mode and wrap from 255 to 0.
REQ-021 cpu_en SHALL be ~reset & (mode_run | step_pulse), where mode_run = ~(synchronized ena_switch).
REQ-022 In free-run mode cpu_en SHALL be 1 every cycle, independent of push.
REQ-023 In single-step mode cpu_en SHALL equal step_pulse.
REQ-024 A mode change SHALL take effect SYNC_STAGES edges after ena_switch changes and SHALL NOT reset the FSM or step_count.
REQ-025 If a pulse coincides with a mode change, that pulse SHALL still assert cpu_en once and count once.

Reset
REQ-026 While reset=1 at a rising edge, the block SHALL load: all synchronizer flops 0, FSM IDLE, counter 0, step_pulse 0, step_count 0.
REQ-027 cpu_en SHALL be 0 while reset is high and SHALL be 1 from the first cycle after release when ena_switch=0.
REQ-028 Reset asserted mid-debounce (DB_PRESS or DB_RELEASE) SHALL abandon the press with no pulse.

Structure
REQ-029 Package step_ctrl_pkg SHALL hold the FSM state enum and default constants for DEBOUNCE_CYCLES and SYNC_STAGES.
REQ-030 A sub-module sync_ff (parameterized width and depth, synchronous reset) SHALL be instantiated for push, ena_switch and switches_in.

Verification
(All scenarios use DEBOUNCE_CYCLES=4 and SYNC_STAGES=2.)
REQ-031 Reset: reset=1 for 3 cycles, ena_switch=0 -> cpu_en=0, step_count=0, sw_sync=0 during reset; cpu_en=1 on the first cycle after release.
REQ-032 Free-run: ena_switch=0, switches_in=3'b111, push toggled randomly for 100 cycles -> sw_sync=3'b111 after 2 edges, cpu_en constantly 1, step_count counts only debounced presses.
REQ-033 Clean press: ena_switch=1, push high for 20 cycles -> exactly one cpu_en/step_pulse cycle, following the 6th edge after push is first sampled; step_count=1.
REQ-034 Bounce: push pattern high 2, low 1, high 3, low 1, then high 10 -> single pulse only after the final steady run; release bounce low 2 / high 1 / low 10 -> no extra pulse.
REQ-035 Wrap and hold: 256 clean presses -> step_count returns to 0; one press held for 1000 cycles -> exactly one pulse.
REQ-036 Reset mid-debounce: reset asserted 2 cycles into DB_PRESS -> no pulse, FSM IDLE, step_count=0; next clean press gives step_count=1.

Source files
------------

// File: rtl/step_ctrl_pkg.sv
// Shared types and defaults for the single-step clock controller.
package step_ctrl_pkg;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 500000;  // 10 ms at 50 MHz
  localparam int unsigned DEF_SYNC_STAGES     = 2;

  typedef enum logic [1:0] {
    IDLE,
    DB_PRESS,
    HELD,
    DB_RELEASE
  } db_state_e;

  // Counter width able to hold n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-stage flip-flop synchronizer with synchronous clear.
module sync_ff #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/step_clock_ctrl.sv
// Processor clock-enable controller: free-run or one debounced push per step.
//   state      | meaning
//   IDLE       | button released and stable
//   DB_PRESS   | push seen, waiting for it to stay high
//   HELD       | press accepted, waiting for release
//   DB_RELEASE | release seen, waiting for it to stay low
module step_clock_ctrl
  import step_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       ena_switch,
  input  logic [2:0] switches_in,
  output logic       cpu_en,
  output logic [2:0] sw_sync,
  output logic       step_pulse,
  output logic [7:0] step_count
);

  localparam int unsigned    CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic push_s;
  logic ena_s;

  sync_ff #(.WIDTH(1), .DEPTH(SYNC_STAGES)) u_sync_push (
    .clk(clk), .reset(reset), .d_i(push), .q_o(push_s)
  );
  sync_ff #(.WIDTH(1), .DEPTH(SYNC_STAGES)) u_sync_ena (
    .clk(clk), .reset(reset), .d_i(ena_switch), .q_o(ena_s)
  );
  sync_ff #(.WIDTH(3), .DEPTH(SYNC_STAGES)) u_sync_sw (
    .clk(clk), .reset(reset), .d_i(switches_in), .q_o(sw_sync)
  );

  db_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_q, pulse_d;
  logic [7:0]    count_q, count_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      count_q <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (push_s) begin
          state_d = DB_PRESS;
          cnt_d   = '0;
        end
      end
      DB_PRESS: begin
        if (!push_s) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HELD: begin
        if (!push_s) begin
          state_d = DB_RELEASE;
          cnt_d   = '0;
        end
      end
      DB_RELEASE: begin
        // A bounce back high returns to HELD without re-arming the pulse.
        if (push_s) begin
          state_d = HELD;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    count_d = pulse_d ? count_q + 8'd1 : count_q;
  end

  assign step_pulse = pulse_q;
  assign step_count = count_q;
  // Pulse ORed in so a step coinciding with a mode change is never lost.
  assign cpu_en     = ~reset & (~ena_s | pulse_q);

endmodule
